// File: rtl/counter_ctrl.sv
// Programmable timer sequencer around an up-counter: start, pause/resume, abort, one-shot or auto-reload.
// Optional prescaler compiled in with `define COUNTER_CTRL_PRESCALE_EN (PRESCALE cycles per count tick).
module counter_ctrl #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_pause,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [7:0] presc_q;
  assign tick = (presc_q == 8'(PRESCALE - 1));
`else
  logic unused_prescale;
  assign unused_prescale = ^32'(PRESCALE);
  assign tick            = 1'b1;
`endif

  // Pause takes effect on the edge it is sampled, so neither count nor prescaler moves then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      presc_q  <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      if (cmd_abort) begin
        state_q <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        presc_q <= '0;
`endif
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cmd_start) begin
              limit_q  <= cfg_limit;
              reload_q <= cfg_reload;
              count_q  <= '0;
              state_q  <= RUN;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
              presc_q  <= '0;
`endif
            end
          end
          RUN: begin
            if (cmd_pause) begin
              state_q <= PAUSE;
            end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
              presc_q <= tick ? 8'd0 : presc_q + 8'd1;
`endif
              if (tick) begin
                if (count_q == limit_q) begin
                  tc_q <= 1'b1;
                  if (reload_q) begin
                    count_q <= '0;
                  end else begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                end else begin
                  count_q <= count_q + 1'b1;
                end
              end
            end
          end
          PAUSE: begin
            if (cmd_start && !cmd_pause) begin
              state_q <= RUN;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed scenarios then random commands, checked against a cycle model.
module tb_counter_ctrl;

  localparam int W = 8;
`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic         clk;
  logic         rst;
  logic         cmd_start;
  logic         cmd_pause;
  logic         cmd_abort;
  logic [W-1:0] cfg_limit;
  logic         cfg_reload;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy;
  logic         done;
  logic         tc_pulse;

  typedef struct {
    int cnt;
    int st;
    bit tc;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural reference: state as small ints, phase counts elapsed RUN cycles toward a tick.
  int mState = 0;
  int mCount = 0;
  int mLimit = 0;
  int mPhase = 0;
  bit mReload = 0;

  counter_ctrl #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_pause(cmd_pause),
    .cmd_abort(cmd_abort), .cfg_limit(cfg_limit), .cfg_reload(cfg_reload),
    .count(count), .state(state), .busy(busy), .done(done), .tc_pulse(tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelStep();
    exp_t e;
    bit   tc;
    tc = 1'b0;
    if (rst) begin
      mState = 0; mCount = 0; mLimit = 0; mReload = 0; mPhase = 0;
    end else if (cmd_abort) begin
      mState = 0; mCount = 0; mPhase = 0;
    end else if (mState == 0 || mState == 3) begin
      if (cmd_start) begin
        mLimit = int'(cfg_limit); mReload = cfg_reload;
        mCount = 0; mPhase = 0; mState = 1;
      end
    end else if (mState == 2) begin
      if (cmd_start && !cmd_pause) mState = 1;
    end else if (cmd_pause) begin
      mState = 2;
    end else begin
      mPhase++;
      if (mPhase == P) begin
        mPhase = 0;
        tc = (mCount == mLimit);
        if (!tc) mCount++;
        else if (mReload) mCount = 0;
        else mState = 3;
      end
    end
    e.cnt = mCount;
    e.st  = mState;
    e.tc  = tc;
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit a,
                               input int lim, input bit rel, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r; cmd_start = s; cmd_pause = p; cmd_abort = a;
      cfg_limit = W'(lim); cfg_reload = rel;
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic compare(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("count", int'(count), e.cnt);
    compare("state", int'(state), e.st);
    compare("busy", int'(busy), int'(e.st == 1 || e.st == 2));
    compare("done", int'(done), int'(e.st == 3));
    compare("tc_pulse", int'(tc_pulse), int'(e.tc));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int lim;
    rst = 1'b1; cmd_start = 1'b0; cmd_pause = 1'b0; cmd_abort = 1'b0;
    cfg_limit = '0; cfg_reload = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // one-shot limit 5
    applyStimulus(0, 1, 0, 0, 5, 0, 1);
    applyStimulus(0, 0, 0, 0, 9, 1, 8 * P);
    // auto-reload limit 3
    applyStimulus(0, 1, 0, 0, 3, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10 * P);
    // pause at count 4, hold, resume
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 10, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4 * P);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10 * P);
    // abort with pause and start at count 7
    applyStimulus(0, 1, 0, 0, 10, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 7 * P);
    applyStimulus(0, 1, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    // pause+start while paused stays paused
    applyStimulus(0, 1, 0, 0, 6, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 8 * P);
    // limit 0, restart from DONE with limit 2, limit 0 reload
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4 * P);
    applyStimulus(0, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    // reset mid-RUN
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 8, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    // full-range limit with reload
    applyStimulus(0, 1, 0, 0, 255, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 260 * P);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      lim = ($urandom_range(0, 9) == 0) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 12);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                    lim, $urandom_range(0, 1) == 1, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 2);

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
